rice_block_sequencer: RTL

Packet-level controller for the Rice decompression datapath. It consumes the compressed telemetry bitstream one bit per cycle and parses, for each block, the ID option field that selects split parameter k. It then sequences j samples through fundamental-sequence (unary) and split-bit phases and presents each reconstructed sample on a valid/ready output. It sits between the bit-unpacker front end and the sample sink, and drives k_cur to configure the downstream split/concatenate datapath.

---
 rtl/rice_block_sequencer.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/rice_block_sequencer.sv
// Rice block sequencer: parses per-block ID options, walks samples through unary/split/raw
// phases and emits each decoded sample on a valid/ready port. Optional macro: RICE_PREPROC_EN.
module rice_block_sequencer #(
   parameter int N    = 8,
   parameter int ID_W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         stop,
   input  logic [5:0]   j,
   input  logic [7:0]   nblk,
   input  logic         bit_in,
   input  logic         bit_valid,
   output logic         bit_ready,
   output logic [N-1:0] smp_out,
   output logic         smp_valid,
   input  logic         smp_ready,
   output logic [4:0]   k_cur,
   output logic         busy,
   output logic         done,
   output logic         err
);

   typedef enum logic [2:0] {
      S_IDLE, S_ID, S_FS, S_SPLIT, S_RAW, S_EMIT, S_DONE, S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [ID_W-2:0]   id_q, id_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [N-1:0]      q_q, q_d;
   logic [30:0]       r_q, r_d;
   logic [4:0]        k_q, k_d;
   logic              raw_q, raw_d;
   logic [6:0]        smp_cnt_q, smp_cnt_d;
   logic [7:0]        blk_cnt_q, blk_cnt_d;
   logic [N-1:0]      smp_q, smp_d;
   logic              err_q, err_d;
   logic              done_q, done_d;

   logic              take, load;
   logic [N-1:0]      load_val, emit_val;
   logic [ID_W-1:0]   id_full;
   logic [31:0]       r_shift;
   logic [N+31:0]     wide;
   logic [6:0]        j_eff, smp_cnt_inc;
   logic [7:0]        blk_inc;

   assign bit_ready = (state_q == S_ID) || (state_q == S_FS) ||
                      (state_q == S_SPLIT) || (state_q == S_RAW);
   assign busy      = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
   assign smp_valid = (state_q == S_EMIT);
   assign smp_out   = smp_q;
   assign k_cur     = k_q;
   assign done      = done_q;
   assign err       = err_q;

   assign take        = bit_valid && bit_ready;
   assign id_full     = {id_q, bit_in};
   assign r_shift     = {r_q, bit_in};
   // Reconstructed value kept wide so an out-of-range q<<k is seen rather than truncated.
   assign wide        = ({{32{1'b0}}, q_q} << k_q) | {{N{1'b0}}, r_shift};
   assign j_eff       = (j == 6'd0) ? 7'd64 : {1'b0, j};
   assign smp_cnt_inc = smp_cnt_q + 7'd1;
   assign blk_inc     = blk_cnt_q + 8'd1;

`ifdef RICE_PREPROC_EN
   logic [N-1:0] x_prev_q, x_prev_d;
   logic [N-1:0] half, delta;

   assign half  = {1'b0, load_val[N-1:1]};
   assign delta = load_val[0] ? -(half + {{(N-1){1'b0}}, 1'b1}) : half;
   assign emit_val = (state_q == S_RAW) ? load_val : x_prev_q + delta;
`else
   assign emit_val = load_val;
`endif

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      cnt_d     = cnt_q;
      q_d       = q_q;
      r_d       = r_q;
      k_d       = k_q;
      raw_d     = raw_q;
      smp_cnt_d = smp_cnt_q;
      blk_cnt_d = blk_cnt_q;
      err_d     = err_q;
      load      = 1'b0;
      load_val  = '0;
`ifdef RICE_PREPROC_EN
      x_prev_d  = x_prev_q;
`endif
      if (stop && busy) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state_d   = S_ID;
                  err_d     = 1'b0;
                  blk_cnt_d = '0;
                  smp_cnt_d = '0;
                  cnt_d     = '0;
`ifdef RICE_PREPROC_EN
                  x_prev_d  = '0;
`endif
               end
            end
            S_ID: if (take) begin
               id_d  = id_full[ID_W-2:0];
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'(ID_W - 1)) begin
                  cnt_d = '0;
                  q_d   = '0;
                  r_d   = '0;
                  if (&id_full) begin
                     k_d     = 5'(N);
                     raw_d   = 1'b1;
                     state_d = S_RAW;
                  end else begin
                     k_d     = 5'(id_full);
                     raw_d   = 1'b0;
                     state_d = S_FS;
                  end
               end
            end
            S_FS: if (take) begin
               if (bit_in) begin
                  if (k_q == 5'd0) begin
                     load     = 1'b1;
                     load_val = q_q;
                     state_d  = S_EMIT;
                  end else begin
                     cnt_d   = '0;
                     r_d     = '0;
                     state_d = S_SPLIT;
                  end
               end else if (q_q == {N{1'b1}}) begin
                  err_d   = 1'b1;
                  state_d = S_ERR;
               end else begin
                  q_d = q_q + 1'b1;
               end
            end
            S_SPLIT: if (take) begin
               r_d   = r_shift[30:0];
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == k_q - 5'd1) begin
                  if (|wide[N+31:N]) begin
                     err_d   = 1'b1;
                     state_d = S_ERR;
                  end else begin
                     load     = 1'b1;
                     load_val = wide[N-1:0];
                     state_d  = S_EMIT;
                  end
               end
            end
            S_RAW: if (take) begin
               r_d   = r_shift[30:0];
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'(N - 1)) begin
                  load     = 1'b1;
                  load_val = r_shift[N-1:0];
                  state_d  = S_EMIT;
               end
            end
            S_EMIT: if (smp_ready) begin
`ifdef RICE_PREPROC_EN
               x_prev_d = smp_q;
`endif
               q_d   = '0;
               r_d   = '0;
               cnt_d = '0;
               if (smp_cnt_inc == j_eff) begin
                  smp_cnt_d = '0;
                  blk_cnt_d = blk_inc;
                  state_d   = ((nblk != 8'd0) && (blk_inc == nblk)) ? S_DONE : S_ID;
               end else begin
                  smp_cnt_d = smp_cnt_inc;
                  state_d   = raw_q ? S_RAW : S_FS;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign smp_d  = load ? emit_val : smp_q;
   assign done_d = (state_d == S_DONE) && (state_q != S_DONE);

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         id_q      <= '0;
         cnt_q     <= '0;
         q_q       <= '0;
         r_q       <= '0;
         k_q       <= '0;
         raw_q     <= 1'b0;
         smp_cnt_q <= '0;
         blk_cnt_q <= '0;
         smp_q     <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
`ifdef RICE_PREPROC_EN
         x_prev_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         cnt_q     <= cnt_d;
         q_q       <= q_d;
         r_q       <= r_d;
         k_q       <= k_d;
         raw_q     <= raw_d;
         smp_cnt_q <= smp_cnt_d;
         blk_cnt_q <= blk_cnt_d;
         smp_q     <= smp_d;
         err_q     <= err_d;
         done_q    <= done_d;
`ifdef RICE_PREPROC_EN
         x_prev_q  <= x_prev_d;
`endif
      end
   end

endmodule
